sys_arr_strm_loader: RTL and testbench

//  Input-side staging block for the DSP systolic array. Accepts AXI-stream beats of BW fp32 words

---
 rtl/dsp_sys_arr_pkg.sv | 21 ++
 rtl/strm_vec_buf.sv | 73 +++++++
 rtl/sys_arr_strm_loader.sv | 144 ++++++++++++++
 tb/tb_sys_arr_strm_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the DSP systolic-array input staging logic.
package dsp_sys_arr_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } single_float;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } strm_ld_state_t;

endpackage

// File: rtl/strm_vec_buf.sv
// DEPTH-slot register FIFO of {a_vec, b_vec} pairs. A slot is filled one
// beat at a time at wr_ptr and only becomes visible once committed.
module strm_vec_buf
  import dsp_sys_arr_pkg::*;
#(
  parameter  int BW          = 128,
  parameter  int NUM_STRM_IN = 1,
  parameter  int DEPTH       = 2,
  localparam int M           = BW * NUM_STRM_IN / 2,
  localparam int BIW         = (NUM_STRM_IN > 1) ? $clog2(NUM_STRM_IN) : 1,
  localparam int PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                wr_en,
  input  logic [BIW-1:0]      wr_beat,
  input  word_t [BW-1:0]      wr_data,
  input  logic                commit,
  input  logic                pop,
  output word_t [M-1:0]       rd_a,
  output word_t [M-1:0]       rd_b,
  output logic [CW-1:0]       count
);

  // Storage is rounded up to a power of two so pointer indexing is exact;
  // pointers still wrap at DEPTH.
  localparam int MEM_SLOTS = 1 << PW;

  word_t [M-1:0]   mem_a [MEM_SLOTS];
  word_t [M-1:0]   mem_b [MEM_SLOTS];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Scatter the even/odd words of an accepted beat into its slice of the open slot.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int b = 0; b < NUM_STRM_IN; b++) begin
        if (wr_beat == BIW'(b)) begin
          for (int i = 0; i < BW / 2; i++) begin
            mem_a[wr_ptr][b * (BW / 2) + i] <= wr_data[2 * i];
            mem_b[wr_ptr][b * (BW / 2) + i] <= wr_data[2 * i + 1];
          end
        end
      end
    end
  end

  // Pointer and occupancy bookkeeping; commit and pop together leave count unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (commit) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (commit && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !commit) begin
        count <= count - 1'b1;
      end
    end
  end

  assign rd_a = (count != '0) ? mem_a[rd_ptr] : '0;
  assign rd_b = (count != '0) ? mem_b[rd_ptr] : '0;

endmodule

// File: rtl/sys_arr_strm_loader.sv
// Input staging for the systolic array: assembles multi-beat AXI-stream
// input into k-step vector pairs, buffers them and presents them to the core.
module sys_arr_strm_loader
  import dsp_sys_arr_pkg::*;
#(
  parameter  int BW          = 128,
  parameter  int NUM_STRM_IN = 1,
  parameter  int N           = 4,
  parameter  int DEPTH       = 2,
  parameter  int K_REVERSE   = 1,
  localparam int M           = BW * NUM_STRM_IN / 2,
  localparam int KW          = (N > 1) ? $clog2(N) : 1,
  localparam int BIW         = (NUM_STRM_IN > 1) ? $clog2(NUM_STRM_IN) : 1,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  word_t [BW-1:0] in_stream,
  input  logic           in_last,
  output logic           vec_valid,
  input  logic           vec_ready,
  output word_t [M-1:0]  a_vec,
  output word_t [M-1:0]  b_vec,
  output logic [KW-1:0]  k_idx,
  output logic           k_last,
  output logic           done,
  output logic           err
);

  strm_ld_state_t state;
  strm_ld_state_t state_nxt;

  logic           soft_rst;
  logic [CW-1:0]  count;
  logic [BIW-1:0] beat_cnt;
  logic [KW-1:0]  k_cnt;
  logic [KW-1:0]  k_rd;
  logic           accept;
  logic           beat_last;
  logic           k_wr_last;
  logic           final_beat;
  logic           commit;
  logic           pop;

  assign soft_rst   = RST || clear;
  assign in_ready   = (count < CW'(DEPTH)) && (state != DRAIN) && (state != DONE);
  assign accept     = in_valid && in_ready;
  assign beat_last  = (beat_cnt == BIW'(NUM_STRM_IN - 1));
  assign k_wr_last  = (k_cnt == KW'(N - 1));
  assign final_beat = beat_last && k_wr_last;
  assign commit     = accept && beat_last;
  assign vec_valid  = (count != '0);
  assign pop        = vec_valid && vec_ready;
  assign k_last     = vec_valid && (k_rd == KW'(N - 1));
  assign k_idx      = !vec_valid      ? '0 :
                      (K_REVERSE != 0) ? KW'(N - 1) - k_rd : k_rd;
  assign done       = (state == DONE);

  strm_vec_buf #(
    .BW          (BW),
    .NUM_STRM_IN (NUM_STRM_IN),
    .DEPTH       (DEPTH)
  ) u_buf (
    .CLK     (CLK),
    .RST     (soft_rst),
    .wr_en   (accept),
    .wr_beat (beat_cnt),
    .wr_data (in_stream),
    .commit  (commit),
    .pop     (pop),
    .rd_a    (a_vec),
    .rd_b    (b_vec),
    .count   (count)
  );

  // Write-side beat/k counters and the sticky in_last framing check.
  always_ff @(posedge CLK) begin
    if (soft_rst) begin
      beat_cnt <= '0;
      k_cnt    <= '0;
      err      <= 1'b0;
    end else if (accept) begin
      if (beat_last) begin
        beat_cnt <= '0;
        k_cnt    <= k_wr_last ? '0 : k_cnt + 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (in_last != final_beat) begin
        err <= 1'b1;
      end
    end
  end

  // Read-side receive-order counter; pairs leave in the order they were committed.
  always_ff @(posedge CLK) begin
    if (soft_rst) begin
      k_rd <= '0;
    end else if (pop) begin
      k_rd <= k_last ? '0 : k_rd + 1'b1;
    end
  end

  // Matrix-level sequencing state register.
  always_ff @(posedge CLK) begin
    if (soft_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: load until the last k-step commits, drain until it is consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (commit && k_wr_last) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (commit && k_wr_last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && k_last && (count == CW'(1))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sys_arr_strm_loader.sv
// Self-checking bench for sys_arr_strm_loader (BW=4, two beats per pair, N=4).
module tb_sys_arr_strm_loader;

  localparam int NB = 8;

  logic CLK = 1'b0;
  logic RST, clear, in_valid, in_ready, in_last;
  logic vec_valid, vec_ready, k_last, done, err;
  logic [3:0][31:0] in_stream, a_vec, b_vec;
  logic [1:0] k_idx;

  typedef struct {
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    int               k;
    bit               last;
  } pair_t;

  typedef struct {
    int gap_max;
    int rnd_ready;
    int stall_pct;
    int bad_last;
    bit exp_err;
  } vec_t;

  pair_t            exp_q[$];
  pair_t            mon_e;
  logic [3:0][31:0] beats [NB];
  logic             lasts [NB];
  int total = 0, bad = 0;
  int pairs_seen = 0, done_cnt = 0;
  int rdy_mode = 0, stall_pct = 0;

  sys_arr_strm_loader #(
    .BW(4), .NUM_STRM_IN(2), .N(4), .DEPTH(2), .K_REVERSE(1)
  ) dut (
    .CLK(CLK), .RST(RST), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_stream(in_stream), .in_last(in_last),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .a_vec(a_vec), .b_vec(b_vec),
    .k_idx(k_idx), .k_last(k_last), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Randomised consumer backpressure when enabled.
  always @(posedge CLK) begin
    #1;
    if (rdy_mode == 1) vec_ready = ($urandom_range(99) >= stall_pct);
  end

  // Scoreboard: every consumed pair must match the oldest expected pair.
  always @(negedge CLK) begin
    if (vec_valid && vec_ready && !RST && !clear) begin
      pairs_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_pair", 128'(1), 128'(0));
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("a_vec", a_vec, mon_e.a);
        checkOutput("b_vec", b_vec, mon_e.b);
        checkOutput("k_idx", 128'(k_idx), 128'(mon_e.k));
        checkOutput("k_last", 128'(k_last), 128'(mon_e.last));
      end
    end
    if (done) done_cnt++;
  end

  task automatic align();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_clear();
    align();
    in_valid = 1'b0;
    clear = 1'b1;
    align();
    clear = 1'b0;
    exp_q.delete();
    pairs_seen = 0;
    done_cnt = 0;
  endtask

  task automatic rand_beats(input int bad_last);
    for (int p = 0; p < NB; p++) begin
      for (int w = 0; w < 4; w++) beats[p][w] = $urandom;
      lasts[p] = (p == NB - 1);
    end
    if (bad_last == -2) lasts[NB-1] = 1'b0;
    else if (bad_last >= 0) lasts[bad_last] = 1'b1;
  endtask

  // Reference: pair j takes beats 2j and 2j+1; even words feed A, odd feed B;
  // the first pair received is k=N-1.
  task automatic push_expected();
    pair_t e;
    for (int j = 0; j < 4; j++) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 2; i++) begin
          e.a[b*2+i] = beats[j*2+b][2*i];
          e.b[b*2+i] = beats[j*2+b][2*i+1];
        end
      end
      e.k = 3 - j;
      e.last = (j == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_beat(input int p);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_stream = beats[p];
    in_last = lasts[p];
    for (int t = 0; t < 300; t++) begin
      @(negedge CLK);
      if (in_ready) begin
        ok = 1'b1;
        align();
        break;
      end
      align();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!ok) checkOutput("beat_accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic applyStimulus(input int first, input int gap_max);
    for (int p = first; p < NB; p++) begin
      repeat ($urandom_range(gap_max)) align();
      drive_beat(p);
    end
  endtask

  task automatic finish_matrix(input bit exp_err);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge CLK);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("done_timeout", 128'(0), 128'(1));
    repeat (3) @(negedge CLK);
    checkOutput("pairs_delivered", 128'(pairs_seen), 128'(4));
    checkOutput("done_pulses", 128'(done_cnt), 128'(1));
    checkOutput("queue_drained", 128'(exp_q.size()), 128'(0));
    checkOutput("err_end", 128'(err), 128'(exp_err));
    checkOutput("in_ready_idle", 128'(in_ready), 128'(1));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rows [5];
    rows[0] = '{3, 0, 0, -1, 1'b0};
    rows[1] = '{0, 1, 50, -1, 1'b0};
    rows[2] = '{2, 1, 30, 2, 1'b1};
    rows[3] = '{1, 0, 0, -2, 1'b1};
    rows[4] = '{0, 1, 80, -1, 1'b0};

    RST = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_stream = '0; vec_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
    checkOutput("rst_vec_valid", 128'(vec_valid), 128'(0));
    checkOutput("rst_a_vec", a_vec, 128'(0));
    checkOutput("rst_k_idx", 128'(k_idx), 128'(0));
    checkOutput("rst_k_last", 128'(k_last), 128'(0));
    checkOutput("rst_done", 128'(done), 128'(0));
    checkOutput("rst_err", 128'(err), 128'(0));

    // Table-driven random matrices: gaps, backpressure and framing errors.
    for (int r = 0; r < 5; r++) begin
      do_clear();
      rdy_mode = rows[r].rnd_ready;
      stall_pct = rows[r].stall_pct;
      if (rdy_mode == 0) vec_ready = 1'b1;
      rand_beats(rows[r].bad_last);
      push_expected();
      applyStimulus(0, rows[r].gap_max);
      finish_matrix(rows[r].exp_err);
      rdy_mode = 0;
      align();
      vec_ready = 1'b0;
      do_clear();
      @(negedge CLK);
      checkOutput("clear_err", 128'(err), 128'(0));
      checkOutput("clear_in_ready", 128'(in_ready), 128'(1));
    end

    // Fixed beat mapping, then a full buffer holding off a third pair.
    do_clear();
    rdy_mode = 0;
    vec_ready = 1'b0;
    rand_beats(-1);
    beats[0] = {32'd20, 32'd2, 32'd10, 32'd1};
    beats[1] = {32'd40, 32'd4, 32'd30, 32'd3};
    push_expected();
    drive_beat(0);
    drive_beat(1);
    @(negedge CLK);
    checkOutput("map_vec_valid", 128'(vec_valid), 128'(1));
    checkOutput("map_a_vec", a_vec, {32'd4, 32'd3, 32'd2, 32'd1});
    checkOutput("map_b_vec", b_vec, {32'd40, 32'd30, 32'd20, 32'd10});
    checkOutput("map_k_idx", 128'(k_idx), 128'(3));
    checkOutput("map_k_last", 128'(k_last), 128'(0));
    align();
    drive_beat(2);
    drive_beat(3);
    in_valid = 1'b1;
    in_last = 1'b1;
    for (int h = 0; h < 3; h++) begin
      in_stream = {$urandom, $urandom, $urandom, $urandom};
      @(negedge CLK);
      checkOutput("full_in_ready", 128'(in_ready), 128'(0));
      checkOutput("full_k_idx", 128'(k_idx), 128'(3));
      align();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    vec_ready = 1'b1;
    applyStimulus(4, 0);
    finish_matrix(1'b0);
    align();
    vec_ready = 1'b0;

    // Commit and pop on the same edge with one pair buffered.
    do_clear();
    rand_beats(-1);
    push_expected();
    drive_beat(0);
    drive_beat(1);
    drive_beat(2);
    vec_ready = 1'b1;
    drive_beat(3);
    vec_ready = 1'b0;
    @(negedge CLK);
    checkOutput("cp_vec_valid", 128'(vec_valid), 128'(1));
    checkOutput("cp_k_idx", 128'(k_idx), 128'(2));
    checkOutput("cp_pairs", 128'(pairs_seen), 128'(1));
    align();
    vec_ready = 1'b1;
    applyStimulus(4, 1);
    finish_matrix(1'b0);
    align();
    vec_ready = 1'b0;

    // Reset mid-matrix, then a clean matrix.
    do_clear();
    rand_beats(0);
    drive_beat(0);
    drive_beat(1);
    @(negedge CLK);
    checkOutput("pre_rst_err", 128'(err), 128'(1));
    checkOutput("pre_rst_vec_valid", 128'(vec_valid), 128'(1));
    align();
    RST = 1'b1;
    align();
    RST = 1'b0;
    exp_q.delete();
    pairs_seen = 0;
    done_cnt = 0;
    @(negedge CLK);
    checkOutput("mid_rst_in_ready", 128'(in_ready), 128'(1));
    checkOutput("mid_rst_vec_valid", 128'(vec_valid), 128'(0));
    checkOutput("mid_rst_a_vec", a_vec, 128'(0));
    checkOutput("mid_rst_err", 128'(err), 128'(0));
    align();
    rdy_mode = 1;
    stall_pct = 40;
    rand_beats(-1);
    push_expected();
    applyStimulus(0, 1);
    finish_matrix(1'b0);
    rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
